// File: rtl/mlop_pkg.sv
// Shared state encoding and width helper for the multi-operand accumulator.
package mlop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int mlop_clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mlop_rgst.sv
// Generic register: async active-low reset, synchronous clear (wins over load), load enable.
module mlop_rgst #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         ld,
    input  logic [w-1:0] d,
    output logic [w-1:0] q
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mlop_accum.sv
// Framed N-operand accumulator; result registered one edge after the N-th accept.
// Operands stall only outside ACC; result is held until out_ready, with start chaining allowed.
module mlop_accum
    import mlop_pkg::*;
#(
    parameter int  W      = 10,
    parameter int  N      = 199,
    parameter int  SIGNED = 0,
    localparam int SW     = W + mlop_clog2(N),
    localparam int CW     = mlop_clog2(N)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic          clr,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [SW-1:0] out_sum,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic [CW-1:0] cnt
);

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          last_accept;
    logic          out_fire;
    logic          frame_start;
    logic [SW-1:0] acc;
    logic [SW-1:0] ext_data;
    logic [SW-1:0] sum_nxt;
    logic [CW-1:0] cnt_nxt;

    generate
        if (SIGNED != 0) begin : g_sext
            assign ext_data = {{(SW-W){in_data[W-1]}}, in_data};
        end else begin : g_zext
            assign ext_data = {{(SW-W){1'b0}}, in_data};
        end
    endgenerate

    assign in_ready    = (state == ACC);
    assign busy        = (state == ACC);
    assign accept      = in_valid & in_ready;
    assign last_accept = accept & (cnt == CW'(N - 1));
    assign out_fire    = out_valid & out_ready;
    // A frame may begin from IDLE or chain straight out of DONE on the consuming cycle.
    assign frame_start = start & ((state == IDLE) | ((state == DONE) & out_fire));
    assign sum_nxt     = acc + ext_data;
    assign cnt_nxt     = cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = ACC;
            ACC:  if (last_accept) state_nxt = DONE;
            DONE: if (out_fire) state_nxt = start ? ACC : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (last_accept) begin
            out_valid <= 1'b1;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    mlop_rgst #(.w(SW)) u_acc (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (clr | frame_start),
        .ld    (accept),
        .d     (sum_nxt),
        .q     (acc)
    );

    mlop_rgst #(.w(CW)) u_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (clr | frame_start | last_accept),
        .ld    (accept),
        .d     (cnt_nxt),
        .q     (cnt)
    );

    // Abort leaves the previous result visible, so this register never clears synchronously.
    mlop_rgst #(.w(SW)) u_sum (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (1'b0),
        .ld    (last_accept & ~clr),
        .d     (sum_nxt),
        .q     (out_sum)
    );

endmodule
